skid_buffer: RTL and testbench
==============================

Name: skid_buffer

Overview:
- Two-entry valid/ready pipeline slice that feeds a downstream load-enabled register stage. It converts a streaming producer into clean load/data pairs.
- Full throughput: one word per cycle.
- in_ready_o is driven from registered state only, so there is no combinational path from out_ready_i to in_ready_o.
- Placed between any producer and the register stage to break ready-timing paths.

Parameters:
- WIDTH, 32, data word width in bits.
- STALL_CNT_WIDTH, 16, width of the stall counter. Used only when SKID_BUFFER_STALL_CNT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-high: rst_n=1 at a rising edge clears all state.
- in_valid_i  input  1  producer has a word on in_data_i.
- in_ready_o  output  1  buffer accepts a word this cycle.
- in_data_i  input  WIDTH  producer data.
- out_valid_o  output  1  out_data_o holds a valid word.
- out_ready_i  input  1  consumer takes out_data_o this cycle; also drives the downstream register's load_i.
- out_data_o  output  WIDTH  head word.
- stall_count_o  output  STALL_CNT_WIDTH  present only with SKID_BUFFER_STALL_CNT_EN.

Behaviour:
- Handshakes:
  - Input accept when in_valid_i && in_ready_o.
  - Output accept when out_valid_o && out_ready_i.
  - Both evaluated in the same cycle; state updates at the next edge.
- Storage: main register (drives out_data_o) and skid register. State is one of EMPTY, BUSY, FULL.
- EMPTY: out_valid_o=0, in_ready_o=1.
  - in accept -> main<=in_data_i, go BUSY.
  - Otherwise stay.
- BUSY: out_valid_o=1, in_ready_o=1.
  - in accept and out accept -> main<=in_data_i, stay BUSY.
  - in accept only -> skid<=in_data_i, go FULL.
  - out accept only -> go EMPTY.
  - Neither -> hold.
- FULL: out_valid_o=1, in_ready_o=0.
  - out accept -> main<=skid, go BUSY.
  - Otherwise hold. in_valid_i is ignored.
- Latency: a word accepted at edge N appears on out_data_o after that edge, so it is first consumable in cycle N+1.
- Ordering: strict FIFO. Words are never dropped or duplicated.
- out_data_o while out_valid_o=0: holds the last value. Consumers must not use it.
- Producer rules:
  - Producer must hold in_data_i stable while in_valid_i && !in_ready_o.
  - The buffer does not depend on this rule for correctness. It captures only on accept.
- Reset:
  - State goes to EMPTY; main, skid and stall counter go to 0.
  - out_valid_o=0 and out_data_o=0 after the reset edge.
  - in_ready_o is forced to 0 during any cycle in which rst_n=1.
- Reset mid-operation: contents are discarded. No handshake completes in the reset cycle.
- Unknown state encoding: treat as EMPTY.

Optional Feature:
- SKID_BUFFER_STALL_CNT_EN defined:
  - Adds stall_count_o.
  - Increments each cycle with out_valid_o && !out_ready_i.
  - Saturates at all-ones and never wraps.
  - Reset to 0.
- Not defined: no port, no counter logic. Behaviour is otherwise identical.

Decomposition:
- skid_buffer_pkg:
  - typedef enum logic [1:0] skid_state_e {SKID_EMPTY, SKID_BUSY, SKID_FULL}.
  - localparam default width.
- Sub-module: register, two instances (main and skid), each with load_i driven by the state logic.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles with in_valid_i=1 -> in_ready_o=0, out_valid_o=0, out_data_o=0. After release, in_ready_o=1.
- Streaming: out_ready_i=1, send 0x1..0x8 back-to-back -> outputs 0x1..0x8 in order, one per cycle, 1-cycle latency, state never FULL.
- Backpressure: out_ready_i=0, send 0xA then 0xB -> FULL, in_ready_o=0, 0xC held off. Raise out_ready_i -> 0xA, 0xB, 0xC in order.
- Simultaneous in/out accept in BUSY with main=0x5, in 0x6 -> next cycle out_data_o=0x6, state BUSY.
- Reset mid-FULL (main=0x11, skid=0x22) -> EMPTY after one edge; 0x11 and 0x22 never appear.
- With SKID_BUFFER_STALL_CNT_EN, STALL_CNT_WIDTH=2: hold a valid word with out_ready_i=0 for 5 cycles -> stall_count_o=1,2,3,3,3.

Source files
------------

// File: rtl/skid_buffer_pkg.sv
// Shared types and defaults for the two-entry skid buffer.
package skid_buffer_pkg;

    localparam int unsigned SKID_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_buffer_reg.sv
// Load-enabled data register with synchronous active-high clear.
module skid_buffer_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else if (load_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer; in_ready_o depends only on registered state and reset.
// Optional saturating stall counter enabled by defining SKID_BUFFER_STALL_CNT_EN.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = SKID_DEFAULT_WIDTH
`ifdef SKID_BUFFER_STALL_CNT_EN
    ,
    parameter int unsigned STALL_CNT_WIDTH = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o
`ifdef SKID_BUFFER_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0] stall_count_o
`endif
);

    skid_state_e      state;
    skid_state_e      state_next;
    logic             main_load;
    logic             skid_load;
    logic             main_from_skid;
    logic             in_accept;
    logic             out_accept;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] main_data_in;

    // rst_n is active-high here; ready is held low for the whole reset cycle.
    assign in_ready_o  = !rst_n && (state != SKID_FULL);
    assign out_valid_o = (state == SKID_BUSY) || (state == SKID_FULL);
    assign in_accept   = in_valid_i && in_ready_o;
    assign out_accept  = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            SKID_BUSY: begin
                if (in_accept && out_accept) begin
                    main_load = 1'b1;
                end else if (in_accept) begin
                    skid_load  = 1'b1;
                    state_next = SKID_FULL;
                end else if (out_accept) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_accept) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = SKID_BUSY;
                end
            end
            // EMPTY and any unrecognised encoding
            default: begin
                state_next = SKID_EMPTY;
                if (in_accept) begin
                    main_load  = 1'b1;
                    state_next = SKID_BUSY;
                end
            end
        endcase
    end

    assign main_data_in = main_from_skid ? skid_data : in_data_i;

    skid_buffer_reg #(.WIDTH(WIDTH)) u_main (
        .clk    (clk),
        .rst    (rst_n),
        .load_i (main_load),
        .data_i (main_data_in),
        .data_o (out_data_o)
    );

    skid_buffer_reg #(.WIDTH(WIDTH)) u_skid (
        .clk    (clk),
        .rst    (rst_n),
        .load_i (skid_load),
        .data_i (in_data_i),
        .data_o (skid_data)
    );

`ifdef SKID_BUFFER_STALL_CNT_EN
    // Counts cycles a valid word waits on the consumer; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_count_o <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_count_o != '1)) begin
            stall_count_o <= stall_count_o + STALL_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Directed self-checking bench for skid_buffer; covers the stall counter when
// SKID_BUFFER_STALL_CNT_EN is defined.
module tb_skid_buffer;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SKID_BUFFER_STALL_CNT_EN
    logic [1:0]       stall_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    skid_buffer #(
        .WIDTH(WIDTH)
`ifdef SKID_BUFFER_STALL_CNT_EN
        ,
        .STALL_CNT_WIDTH(2)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
`ifdef SKID_BUFFER_STALL_CNT_EN
        ,
        .stall_count_o (stall_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b0;

        // reset held for three edges with a word offered
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", out_data, 32'h0);
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // streaming with consumer always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", out_data, 32'(i));
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", 32'(out_valid), 32'd0);

        // backpressure: A, B fill the buffer, C is held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        in_data = 32'hB;
        step();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_head_a", out_data, 32'hA);
        in_data = 32'hC;
        step();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_a", out_data, 32'hA);
        out_ready = 1'b1;
        step();
        check("bp_head_b", out_data, 32'hB);
        check("bp_busy_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_head_c", out_data, 32'hC);
        check("bp_c_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // simultaneous accept while BUSY
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        step();
        check("sim_main5", out_data, 32'h5);
        in_data   = 32'h6;
        out_ready = 1'b1;
        step();
        check("sim_main6", out_data, 32'h6);
        check("sim_busy_valid", 32'(out_valid), 32'd1);
        check("sim_busy_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        check("sim_drain_valid", 32'(out_valid), 32'd0);

        // reset while FULL discards both entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        check("mid_full_ready", 32'(in_ready), 32'd0);
        check("mid_full_head", out_data, 32'h11);
        rst_n     = 1'b1;
        in_data   = 32'h33;
        out_ready = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, 32'h0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        check("mid_after_valid", 32'(out_valid), 32'd0);
        check("mid_after_data", out_data, 32'h0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        step();
        check("mid_new_head", out_data, 32'h44);
        in_data = 32'h55;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("mid_skid_fresh", out_data, 32'h55);
        step();
        check("mid_final_valid", 32'(out_valid), 32'd0);

`ifdef SKID_BUFFER_STALL_CNT_EN
        // saturating stall counter, 2-bit
        out_ready = 1'b0;
        rst_n     = 1'b1;
        step();
        rst_n = 1'b0;
        check("stall_rst", 32'(stall_count), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h77;
        step();
        in_valid = 1'b0;
        check("stall_start", 32'(stall_count), 32'd0);
        step();
        check("stall_1", 32'(stall_count), 32'd1);
        step();
        check("stall_2", 32'(stall_count), 32'd2);
        step();
        check("stall_3", 32'(stall_count), 32'd3);
        step();
        check("stall_sat_a", 32'(stall_count), 32'd3);
        step();
        check("stall_sat_b", 32'(stall_count), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
